flag_update_unit: RTL and testbench

//   Execute-stage producer of the NZCV condition flags, which the condition evaluator consumes.
//   - Derives N/Z from the ALU result; C/V come from the ALU.
//   - Holds the architectural flag register.
//   - Evaluates the E-stage instruction's condition against the current (pre-update) flags.
//   - Gates that instruction's flag write and its reg/mem/PC side effects.
//   - Registers the gated controls into the M stage.

---
 rtl/flag_update_unit_pkg.sv | 34 +++
 rtl/flag_update_unit_if.sv | 32 +++
 rtl/flag_update_unit_cond_eval.sv | 38 +++
 rtl/flag_update_unit.sv | 68 ++++++
 tb/tb_flag_update_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/flag_update_unit_pkg.sv
// Shared definitions for the execute-stage flag unit: condition codes,
// flag bit positions and flag-write enable indices.
package flag_update_unit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

endpackage

// File: rtl/flag_update_unit_if.sv
// E-stage control/ALU inputs and flag/M-stage outputs of the flag unit.
interface flag_update_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall_e;
  logic             flush_e;
  logic [3:0]       cond_e;
  logic [1:0]       flag_write_e;
  logic [WIDTH-1:0] alu_result_e;
  logic             alu_carry_e;
  logic             alu_ovf_e;
  logic             reg_write_e;
  logic             mem_write_e;
  logic             pcsrc_e;
  logic [3:0]       flags;
  logic             cond_ex_e;
  logic             reg_write_m;
  logic             mem_write_m;
  logic             pcsrc_m;

  modport master (
    output stall_e, flush_e, cond_e, flag_write_e, alu_result_e,
           alu_carry_e, alu_ovf_e, reg_write_e, mem_write_e, pcsrc_e,
    input  flags, cond_ex_e, reg_write_m, mem_write_m, pcsrc_m
  );

  modport slave (
    input  stall_e, flush_e, cond_e, flag_write_e, alu_result_e,
           alu_carry_e, alu_ovf_e, reg_write_e, mem_write_e, pcsrc_e,
    output flags, cond_ex_e, reg_write_m, mem_write_m, pcsrc_m
  );
endinterface

// File: rtl/flag_update_unit_cond_eval.sv
// Combinational ARM condition check of a 4-bit condition field against NZCV.
module flag_update_unit_cond_eval
  import flag_update_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b1;
    case (cond_t'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_update_unit.sv
// Execute-stage NZCV producer: holds the flag register, evaluates the E-stage
// condition on the current flags and gates flag/reg/mem/PC writes into M.
module flag_update_unit
  import flag_update_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  flag_update_unit_if.slave  bus
);

  logic [3:0] flags_q, flags_d;
  logic       reg_write_m_q, reg_write_m_d;
  logic       mem_write_m_q, mem_write_m_d;
  logic       pcsrc_m_q, pcsrc_m_d;
  logic       n_c, z_c;
  logic       pass_c;
  logic       commit_c;

  assign n_c = bus.alu_result_e[WIDTH-1];
  assign z_c = (bus.alu_result_e == WIDTH'(0));

  // Condition is judged on the registered flags only; no same-cycle bypass.
  flag_update_unit_cond_eval u_cond_eval (
    .cond_i  (bus.cond_e),
    .flags_i (flags_q),
    .pass_o  (pass_c)
  );

  assign commit_c = pass_c & ~(bus.stall_e | bus.flush_e);

  always_comb begin
    flags_d       = flags_q;
    reg_write_m_d = bus.reg_write_e & commit_c;
    mem_write_m_d = bus.mem_write_e & commit_c;
    pcsrc_m_d     = bus.pcsrc_e & commit_c;
    if (commit_c && bus.flag_write_e[FW_NZ]) begin
      flags_d[FLAG_N] = n_c;
      flags_d[FLAG_Z] = z_c;
    end
    if (commit_c && bus.flag_write_e[FW_CV]) begin
      flags_d[FLAG_C] = bus.alu_carry_e;
      flags_d[FLAG_V] = bus.alu_ovf_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= 4'b0000;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      pcsrc_m_q     <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
      pcsrc_m_q     <= pcsrc_m_d;
    end
  end

  assign bus.flags       = flags_q;
  assign bus.cond_ex_e   = pass_c;
  assign bus.reg_write_m = reg_write_m_q;
  assign bus.mem_write_m = mem_write_m_q;
  assign bus.pcsrc_m     = pcsrc_m_q;

endmodule

// File: tb/tb_flag_update_unit.sv
// Scoreboard bench for flag_update_unit: directed spec scenarios plus random
// traffic checked against an abstract NZCV/condition model.
module tb_flag_update_unit;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [3:0] flags;
    logic       rw;
    logic       mw;
    logic       pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  flag_update_unit_if #(.WIDTH(W)) bus ();

  flag_update_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [3:0] model_flags = 4'b0000;
  logic pass_tab [16];

  // Conditions come in true/inverted pairs; 111x always pass.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %4b expected %4b at %0t", name, act, req, $time);
    end
  endtask

  // Apply one E-stage cycle, check the combinational condition, queue the M result.
  task automatic drive(input logic rst, input logic st, input logic fl,
                       input logic [3:0] c, input logic [1:0] fw,
                       input logic [W-1:0] res, input logic cy, input logic ov,
                       input logic rw, input logic mw, input logic pc);
    exp_t e;
    logic p, ok;
    @(negedge clk);
    reset            = rst;
    bus.stall_e      = st;
    bus.flush_e      = fl;
    bus.cond_e       = c;
    bus.flag_write_e = fw;
    bus.alu_result_e = res;
    bus.alu_carry_e  = cy;
    bus.alu_ovf_e    = ov;
    bus.reg_write_e  = rw;
    bus.mem_write_e  = mw;
    bus.pcsrc_e      = pc;
    #1;
    p = ref_pass(c, model_flags);
    check1("cond_ex_e", bus.cond_ex_e, p);
    ok = p && !st && !fl && !rst;
    e.flags = model_flags;
    if (rst) e.flags = 4'b0000;
    else if (ok) begin
      if (fw[1]) e.flags[3:2] = {res[W-1], res == '0};
      if (fw[0]) e.flags[1:0] = {cy, ov};
    end
    e.rw = rw && ok;
    e.mw = mw && ok;
    e.pc = pc && ok;
    model_flags = e.flags;
    exp_q.push_back(e);
  endtask

  task automatic nop(input logic [3:0] c);
    drive(1'b0, 1'b0, 1'b0, c, 2'b00, W'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every edge the registered outputs reflect the oldest queued cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check4("flags", bus.flags, e.flags);
        check1("reg_write_m", bus.reg_write_m, e.rw);
        check1("mem_write_m", bus.mem_write_m, e.mw);
        check1("pcsrc_m", bus.pcsrc_m, e.pc);
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    reset = 1'b1;
    bus.stall_e = 1'b0; bus.flush_e = 1'b0; bus.cond_e = 4'b0000;
    bus.flag_write_e = 2'b11; bus.alu_result_e = '0; bus.alu_carry_e = 1'b1;
    bus.alu_ovf_e = 1'b1; bus.reg_write_e = 1'b1; bus.mem_write_e = 1'b1;
    bus.pcsrc_e = 1'b1;

    // Reset with random side inputs; EQ on zero flags fails.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'($urandom), 1'($urandom), 4'b0000, 2'($urandom), $urandom,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    nop(4'b0000);
    check4("flags_after_reset", bus.flags, 4'b0000);
    check1("eq_after_reset", bus.cond_ex_e, 1'b0);

    // Zero result sets Z, carry sets C.
    drive(1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, W'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(4'b0000);
    check4("flags_0110", bus.flags, 4'b0110);
    check1("eq_pass", bus.cond_ex_e, 1'b1);
    nop(4'b0001);
    check1("ne_fail", bus.cond_ex_e, 1'b0);

    // Failed NE suppresses both the flag write and reg write.
    drive(1'b0, 1'b0, 1'b0, 4'b0001, 2'b11, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    nop(4'b1110);
    check4("ne_no_update", bus.flags, 4'b0110);

    // Partial NZ write leaves C,V held.
    drive(1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, W'(1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'b1110, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nop(4'b1110);
    check4("nz_only", bus.flags, 4'b1011);

    // Stall, flush, both: bubbles and no flag change; then a clean op updates.
    drive(1'b0, 1'b1, 1'b0, 4'b1110, 2'b11, W'(0), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 4'b1110, 2'b11, W'(0), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 4'b1110, 2'b11, W'(0), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, W'(0), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    nop(4'b1110);
    check4("clean_after_kill", bus.flags, 4'b0101);

    // Sweep every reachable flag value (N and Z never both set) x all conds.
    for (int f = 0; f < 16; f++) begin
      if (f[3] && f[2]) continue;
      r = f[2] ? W'(0) : (f[3] ? 32'h8000_0000 : W'(7));
      drive(1'b0, 1'b0, 1'b0, 4'b1110, 2'b11, r, f[1], f[0], 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        nop(4'(c));
        pass_tab[c] = bus.cond_ex_e;
      end
      check1("gt_le_compl", pass_tab[12], !pass_tab[13]);
      check1("ge_lt_compl", pass_tab[10], !pass_tab[11]);
    end

    // Random traffic with occasional stall/flush/reset.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 32'h8000_0000 | W'($urandom);
        default: r = W'($urandom);
      endcase
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, 4'($urandom), 2'($urandom), r,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    nop(4'b1110);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
